int_ctrl: RTL

- Reset and interrupt sequencer sitting directly upstream of proc.
- Generates proc's resetn and holds it for a fixed count after system reset.
- Synchronizes the external nmi_n/irq_n pins, latches NMI edges, and applies IRQ masking.
- Presents proc with a prioritized interrupt request plus the 16-bit vector address through a req/ack handshake.

---
 rtl/int_ctrl.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/int_ctrl.sv
// Reset and interrupt sequencer for proc: holds proc in reset, then arbitrates
// reset/NMI/IRQ requests and presents the vector through a req/ack handshake.
module int_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int RESET_HOLD  = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        nmi_n,
  input  logic        irq_n,
  input  logic        i_flag,
  input  logic        int_ack,
  output logic        proc_resetn,
  output logic        int_req,
  output logic [15:0] int_vector,
  output logic        int_is_nmi,
  output logic        int_is_reset
);

  localparam int CW = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'(RESET_HOLD - 1);

  localparam logic [15:0] VEC_NMI   = 16'hFFFA;
  localparam logic [15:0] VEC_RESET = 16'hFFFC;
  localparam logic [15:0] VEC_IRQ   = 16'hFFFE;

  typedef enum logic [2:0] {
    ST_HOLD,
    ST_RST_REQ,
    ST_IDLE,
    ST_NMI_REQ,
    ST_IRQ_REQ
  } state_t;

  state_t state_reg, state_next;

  logic [CW-1:0] hold_cnt_reg, hold_cnt_next;
  logic          nmi_prev_reg;
  logic          nmi_latch_reg, nmi_latch_next;
  logic          irq_active_reg;
  logic          nmi_edge;

  logic          proc_resetn_reg, proc_resetn_next;
  logic          int_req_reg, int_req_next;
  logic [15:0]   int_vector_reg, int_vector_next;
  logic          int_is_nmi_reg, int_is_nmi_next;
  logic          int_is_reset_reg, int_is_reset_next;

  // Bit 0 carries nmi_n, bit 1 carries irq_n through identical chains.
  logic [1:0] pin_n;
  logic [1:0] pin_sync;
  assign pin_n = {irq_n, nmi_n};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_sync
      logic [SYNC_STAGES-1:0] chain_reg;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          chain_reg <= '1;
        end else begin
          chain_reg <= {chain_reg[SYNC_STAGES-2:0], pin_n[gi]};
        end
      end
      assign pin_sync[gi] = chain_reg[SYNC_STAGES-1];
    end
  endgenerate

  assign nmi_edge = nmi_prev_reg & ~pin_sync[0];

  always_comb begin
    state_next     = state_reg;
    hold_cnt_next  = hold_cnt_reg;
    nmi_latch_next = nmi_latch_reg;

    case (state_reg)
      ST_HOLD: begin
        hold_cnt_next = hold_cnt_reg + CW'(1);
        if (hold_cnt_reg == HOLD_LAST) begin
          state_next = ST_RST_REQ;
        end
      end
      ST_RST_REQ: begin
        if (int_ack) state_next = ST_IDLE;
      end
      ST_IDLE: begin
        if (nmi_latch_reg)       state_next = ST_NMI_REQ;
        else if (irq_active_reg) state_next = ST_IRQ_REQ;
      end
      ST_NMI_REQ: begin
        if (int_ack) state_next = ST_IDLE;
      end
      ST_IRQ_REQ: begin
        if (int_ack)              state_next = ST_IDLE;
        else if (nmi_latch_reg)   state_next = ST_NMI_REQ;
        else if (!irq_active_reg) state_next = ST_IDLE;
      end
      default: state_next = ST_HOLD;
    endcase

    // A fresh edge coinciding with the NMI ack keeps the latch set.
    if (nmi_edge) begin
      nmi_latch_next = 1'b1;
    end else if (state_reg == ST_NMI_REQ && int_ack) begin
      nmi_latch_next = 1'b0;
    end
  end

  // Outputs are registered copies of what the next state presents.
  always_comb begin
    proc_resetn_next  = (state_next != ST_HOLD);
    int_req_next      = 1'b0;
    int_vector_next   = int_vector_reg;
    int_is_nmi_next   = 1'b0;
    int_is_reset_next = 1'b0;
    case (state_next)
      ST_RST_REQ: begin
        int_req_next      = 1'b1;
        int_vector_next   = VEC_RESET;
        int_is_reset_next = 1'b1;
      end
      ST_NMI_REQ: begin
        int_req_next    = 1'b1;
        int_vector_next = VEC_NMI;
        int_is_nmi_next = 1'b1;
      end
      ST_IRQ_REQ: begin
        int_req_next    = 1'b1;
        int_vector_next = VEC_IRQ;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg        <= ST_HOLD;
      hold_cnt_reg     <= '0;
      nmi_prev_reg     <= 1'b1;
      nmi_latch_reg    <= 1'b0;
      irq_active_reg   <= 1'b0;
      proc_resetn_reg  <= 1'b0;
      int_req_reg      <= 1'b0;
      int_vector_reg   <= VEC_RESET;
      int_is_nmi_reg   <= 1'b0;
      int_is_reset_reg <= 1'b0;
    end else begin
      state_reg        <= state_next;
      hold_cnt_reg     <= hold_cnt_next;
      nmi_prev_reg     <= pin_sync[0];
      nmi_latch_reg    <= nmi_latch_next;
      irq_active_reg   <= ~pin_sync[1] & ~i_flag;
      proc_resetn_reg  <= proc_resetn_next;
      int_req_reg      <= int_req_next;
      int_vector_reg   <= int_vector_next;
      int_is_nmi_reg   <= int_is_nmi_next;
      int_is_reset_reg <= int_is_reset_next;
    end
  end

  assign proc_resetn  = proc_resetn_reg;
  assign int_req      = int_req_reg;
  assign int_vector   = int_vector_reg;
  assign int_is_nmi   = int_is_nmi_reg;
  assign int_is_reset = int_is_reset_reg;

endmodule
